brs_seq_ctl: RTL and testbench

//   Sequencing front-end for the 8-bit combinational 3-level logarithmic right shifter.

---
 rtl/brs_seq_ctl.sv | 94 +++++++++
 tb/tb_brs_seq_ctl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/brs_seq_ctl.sv
// rtl/brs_seq_ctl.sv - sequencing front-end for an 8-bit 3-level log right shifter
// Splits large shift amounts into passes of at most 7 and returns the result over valid/ready.
module brs_seq_ctl #(
  parameter int SAW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [7:0]     req_data,
  input  logic [SAW-1:0] req_shamt,
  output logic [7:0]     sh_x,
  output logic [2:0]     sh_ct,
  input  logic [7:0]     sh_y,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [7:0]     rsp_data,
  output logic           busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t         r_state;
  logic [7:0]     r_acc;
  logic [SAW-1:0] r_rem;
  logic           r_rsp_valid;
  logic           r_busy;

  logic [2:0]     w_chunk;
  logic [SAW-1:0] w_rem_next;

  // Largest pass the 3-level shifter supports is 7; the final pass takes the remainder.
  assign w_chunk    = (r_rem > SAW'(7)) ? 3'd7 : r_rem[2:0];
  assign w_rem_next = r_rem - SAW'(w_chunk);

  assign req_ready = (r_state == S_IDLE) && !rst;
  assign sh_x      = r_acc;
  assign sh_ct     = (r_state == S_SHIFT) ? w_chunk : 3'd0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_acc;
  assign busy      = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= 8'd0;
      r_rem       <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_acc  <= req_data;
            r_rem  <= req_shamt;
            r_busy <= 1'b1;
            if (req_shamt == '0) begin
              r_state     <= S_HOLD;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          // Shifter is combinational: sh_y already reflects sh_x/sh_ct on this edge.
          r_acc <= sh_y;
          r_rem <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state     <= S_HOLD;
            r_rsp_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brs_seq_ctl.sv
// tb/tb_brs_seq_ctl.sv - self-checking bench for brs_seq_ctl
// Vector table, hand sequences for backpressure/reset, and randomized scoreboard run.
module tb_brs_seq_ctl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic [3:0] req_shamt;
  logic [7:0] sh_x;
  logic [2:0] sh_ct;
  logic [7:0] sh_y;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  brs_seq_ctl #(.SAW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .sh_x      (sh_x),
    .sh_ct     (sh_ct),
    .sh_y      (sh_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // The downstream combinational shifter.
  assign sh_y = sh_x >> sh_ct;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] d;
    logic [3:0] s;
    logic [7:0] exp_y;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Presents one request from IDLE, checks each pass's count and the overall latency.
  task automatic send_req(input logic [7:0] d, input logic [3:0] s);
    int rem;
    int edges;
    int ch;
    req_valid = 1'b1;
    req_data  = d;
    req_shamt = s;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    req_data  = 8'($urandom);
    req_shamt = 4'($urandom);
    edges = 1;
    rem   = int'(s);
    while (!rsp_valid && edges < 40) begin
      ch = (rem > 7) ? 7 : rem;
      chk("sh_ct_pass", 32'(sh_ct), 32'(ch));
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      rem = rem - ch;
      tick();
      edges++;
    end
    chk("latency", 32'(edges), 32'((int'(s) + 6) / 7 + 1));
    chk("busy_hold", 32'(busy), 32'd1);
    chk("sh_ct_hold", 32'(sh_ct), 32'd0);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    chk("rsp_valid_hold", 32'(rsp_valid), 32'd1);
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("req_ready_after", 32'(req_ready), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  logic [7:0] q[$];
  int         acc_n;
  int         rsp_n;
  int         cyc;
  logic       fire_req;
  logic       fire_rsp;
  logic [7:0] cap;
  logic       saw_rsp;

  initial begin
    vecs[0] = '{8'hB4, 4'd3,  8'h16};
    vecs[1] = '{8'h80, 4'd10, 8'h00};
    vecs[2] = '{8'hF0, 4'd0,  8'hF0};
    vecs[3] = '{8'hFF, 4'd15, 8'h00};
    vecs[4] = '{8'hFF, 4'd7,  8'h01};
    vecs[5] = '{8'hFF, 4'd8,  8'h00};
    vecs[6] = '{8'h81, 4'd1,  8'h40};
    vecs[7] = '{8'h3C, 4'd14, 8'h00};
    vecs[8] = '{8'h96, 4'd4,  8'h09};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_data  = 8'h00;
    req_shamt = 4'h0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sh_ct", 32'(sh_ct), 32'd0);
    chk("rst_sh_x", 32'(sh_x), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("release_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      send_req(vecs[i].d, vecs[i].s);
      chk("vec_rsp_data", 32'(rsp_data), 32'(vecs[i].exp_y));
      take_rsp();
    end

    // Backpressure in HOLD with a competing request that must be ignored.
    send_req(8'hFF, 4'd15);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_data  = 8'hA5;
      req_shamt = 4'd1;
      chk("bp_rsp_data", 32'(rsp_data), 32'h00);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      tick();
    end
    req_valid = 1'b0;
    take_rsp();
    chk("bp_no_extra", 32'(sh_x), 32'h00);

    // Reset during the second SHIFT pass discards the request.
    req_valid = 1'b1;
    req_data  = 8'hFF;
    req_shamt = 4'd15;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_sh_ct", 32'(sh_ct), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_acc", 32'(sh_x), 32'd0);
    rsp_ready = 1'b1;
    saw_rsp   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) saw_rsp = 1'b1;
      tick();
    end
    rsp_ready = 1'b0;
    chk("mid_rst_no_rsp", 32'(saw_rsp), 32'd0);

    // Randomized traffic against an in-order scoreboard of data >> shamt.
    acc_n = 0;
    rsp_n = 0;
    cyc   = 0;
    while (rsp_n < 200 && cyc < 20000) begin
      req_valid = (acc_n < 200) && ($urandom_range(0, 3) != 0);
      req_data  = 8'($urandom);
      req_shamt = 4'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      fire_req = req_valid && req_ready;
      fire_rsp = rsp_valid && rsp_ready;
      cap      = rsp_data;
      if (fire_req) begin
        q.push_back(req_data >> req_shamt);
        acc_n++;
      end
      if (fire_rsp) begin
        if (q.size() == 0) chk("rand_rsp_extra", 32'd1, 32'd0);
        else chk("rand_rsp", 32'(cap), 32'(q.pop_front()));
        rsp_n++;
      end
      tick();
      cyc++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("rand_count", 32'(rsp_n), 32'd200);
    chk("rand_q_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
